// File: rtl/vpu_seq_pkg.sv
// Shared types for the VPU hyper-block job sequencer: job record, stage states
// and the configuration range check used by the top at elaboration.
package vpu_seq_pkg;

  localparam int N_MAX     = 8;
  localparam int MODE_MAX  = 8;
  localparam int STAGE_MAX = 8;
  localparam int TAG_MAX   = 16;

  // Fields are sized for the largest legal configuration; the top zero-extends.
  typedef struct packed {
    logic [N_MAX-1:0]     n;
    logic [MODE_MAX-1:0]  mode;
    logic [STAGE_MAX-1:0] skip;
    logic [TAG_MAX-1:0]   tag;
    logic                 err;
  } job_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } stage_state_t;

  function automatic bit cfg_ok(input int num_stages, input int power_width,
                                input int mode_width, input int tag_width,
                                input int job_depth, input int timeout_width);
    return (num_stages >= 1) && (num_stages <= STAGE_MAX) &&
           (power_width >= 1) && (power_width <= N_MAX) &&
           (mode_width >= 1) && (mode_width <= MODE_MAX) &&
           (tag_width >= 1) && (tag_width <= TAG_MAX) &&
           (job_depth >= 2) && ((job_depth & (job_depth - 1)) == 0) &&
           (timeout_width >= 2) && (timeout_width <= 32);
  endfunction

endpackage

// File: rtl/vpu_seq_stage.sv
// One sequencer stage: IDLE/RUN/HOLD FSM, per-job watchdog and the hand-off
// register feeding the next stage (absent on the last stage).
module vpu_seq_stage
  import vpu_seq_pkg::*;
#(
  parameter int STAGE         = 0,
  parameter bit IS_LAST       = 1'b0,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr_err,
  input  logic         src_valid,
  input  job_t         src_job,
  output logic         src_pop,
  input  logic         done,
  output logic         start,
  output job_t         view_job,
  output logic         hand,
  output job_t         job,
  output logic         h_valid,
  output job_t         h_job,
  input  logic         h_pop,
  output logic         err_timeout,
  output stage_state_t state
);

  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = TIMEOUT_WIDTH'(1);
  // The counter reaches all-ones on the cycle the error becomes visible.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_FIRE = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  stage_state_t             state_next;
  logic [TIMEOUT_WIDTH-1:0] wd;
  logic                     take;
  logic                     timeout;
  logic                     skip_eff;
  logic                     dst_free;

  assign skip_eff = src_job.skip[STAGE] | src_job.err;
  assign dst_free = IS_LAST ? 1'b1 : (!h_valid || h_pop);
  assign src_pop  = take;
  assign view_job = take ? src_job : job;

  always_comb begin
    state_next = state;
    take       = 1'b0;
    start      = 1'b0;
    hand       = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (src_valid && en) begin
          take = 1'b1;
          if (skip_eff) begin
            state_next = ST_HOLD;
          end else begin
            state_next = ST_RUN;
            start      = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (done) begin
          state_next = ST_HOLD;
        end else if (wd == WD_FIRE) begin
          state_next = ST_HOLD;
          timeout    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (dst_free) begin
          hand       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job         <= '0;
      wd          <= '0;
      h_valid     <= 1'b0;
      h_job       <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (take) begin
        job <= src_job;
        wd  <= WD_ONE;
      end else if (state == ST_RUN) begin
        wd <= wd + WD_ONE;
      end
      if (timeout) begin
        job.err     <= 1'b1;
        err_timeout <= 1'b1;
      end else if (clr_err) begin
        err_timeout <= 1'b0;
      end
      if (!IS_LAST) begin
        if (hand) begin
          h_valid <= 1'b1;
          h_job   <= job;
        end else if (h_pop) begin
          h_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/vpu_chain_seq.sv
// Job sequencer for a chain of VPU stages: job FIFO feeding NUM_STAGES
// in-order stages, with per-stage skip, watchdog and sticky error flags.
module vpu_chain_seq
  import vpu_seq_pkg::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int POWER_WIDTH   = 4,
  parameter int MODE_WIDTH    = 2,
  parameter int TAG_WIDTH     = 4,
  parameter int JOB_DEPTH     = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_en,
  input  logic                              i_start,
  input  logic [POWER_WIDTH-1:0]            i_n,
  input  logic [MODE_WIDTH-1:0]             i_mode,
  input  logic [NUM_STAGES-1:0]             i_skip,
  input  logic [TAG_WIDTH-1:0]              i_tag,
  output logic                              o_ready,
  output logic [$clog2(JOB_DEPTH):0]        o_level,
  output logic [NUM_STAGES-1:0]             o_start,
  output logic [NUM_STAGES*POWER_WIDTH-1:0] o_n_stage,
  output logic [NUM_STAGES*MODE_WIDTH-1:0]  o_mode_stage,
  input  logic [NUM_STAGES-1:0]             i_done,
  output logic                              o_done,
  output logic [TAG_WIDTH-1:0]              o_done_tag,
  output logic                              o_done_err,
  output logic                              o_busy,
  output logic [NUM_STAGES-1:0]             o_err_timeout,
  output logic                              o_err_overflow,
  input  logic                              i_clr_err
);

  localparam int AW = $clog2(JOB_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(JOB_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  if (!cfg_ok(NUM_STAGES, POWER_WIDTH, MODE_WIDTH, TAG_WIDTH, JOB_DEPTH, TIMEOUT_WIDTH)) begin : g_bad_cfg
    $error("vpu_chain_seq: parameter out of range");
  end

  job_t          fifo_mem [JOB_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          en_q;
  job_t          push_job;

  job_t         src_job  [NUM_STAGES];
  job_t         h_job    [NUM_STAGES];
  job_t         view_job [NUM_STAGES];
  job_t         st_job   [NUM_STAGES];
  stage_state_t st_state [NUM_STAGES];
  logic [NUM_STAGES-1:0] src_valid;
  logic [NUM_STAGES-1:0] src_pop;
  logic [NUM_STAGES-1:0] h_valid;
  logic [NUM_STAGES-1:0] h_pop;
  logic [NUM_STAGES-1:0] hand;
  logic [NUM_STAGES-1:0] occ;

  assign push = i_start && o_ready;
  assign pop  = src_pop[0];

  always_comb begin
    push_job                        = '0;
    push_job.n[POWER_WIDTH-1:0]     = i_n;
    push_job.mode[MODE_WIDTH-1:0]   = i_mode;
    push_job.skip[NUM_STAGES-1:0]   = i_skip;
    push_job.tag[TAG_WIDTH-1:0]     = i_tag;
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_job;
    end
  end

  // i_en is registered so a rising enable issues on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_ready        <= 1'b1;
      o_err_overflow <= 1'b0;
      en_q           <= 1'b0;
    end else begin
      en_q    <= i_en;
      count   <= count_next;
      o_ready <= (count_next != DEPTH_L);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (i_start && !o_ready) begin
        o_err_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_err_overflow <= 1'b0;
      end
    end
  end

  assign o_level = count;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_src_fifo
      assign src_valid[s] = (count != '0);
      assign src_job[s]   = fifo_mem[rd_ptr];
    end else begin : g_src_hand
      assign src_valid[s] = h_valid[s-1];
      assign src_job[s]   = h_job[s-1];
    end

    if (s == NUM_STAGES - 1) begin : g_pop_last
      assign h_pop[s] = 1'b0;
    end else begin : g_pop_mid
      assign h_pop[s] = src_pop[s+1];
    end

    vpu_seq_stage #(
      .STAGE         (s),
      .IS_LAST       (s == NUM_STAGES - 1),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en_q),
      .clr_err     (i_clr_err),
      .src_valid   (src_valid[s]),
      .src_job     (src_job[s]),
      .src_pop     (src_pop[s]),
      .done        (i_done[s]),
      .start       (o_start[s]),
      .view_job    (view_job[s]),
      .hand        (hand[s]),
      .job         (st_job[s]),
      .h_valid     (h_valid[s]),
      .h_job       (h_job[s]),
      .h_pop       (h_pop[s]),
      .err_timeout (o_err_timeout[s]),
      .state       (st_state[s])
    );

    assign o_n_stage[s*POWER_WIDTH +: POWER_WIDTH]  = view_job[s].n[POWER_WIDTH-1:0];
    assign o_mode_stage[s*MODE_WIDTH +: MODE_WIDTH] = view_job[s].mode[MODE_WIDTH-1:0];
    assign occ[s] = (st_state[s] != ST_IDLE) || h_valid[s];
  end

  assign o_done     = hand[NUM_STAGES-1];
  assign o_done_tag = o_done ? st_job[NUM_STAGES-1].tag[TAG_WIDTH-1:0] : '0;
  assign o_done_err = o_done && st_job[NUM_STAGES-1].err;
  assign o_busy     = (count != '0) || (|occ);

endmodule
